// File: rtl/hmmm_loader.sv
// hmmm_loader: loads a host program into the CPU, then bridges CPU reads/writes to host word handshakes
module hmmm_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [7:0]  load_count,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        pgrm_addr,
  output logic        pgrm_data,
  output logic        cpu_rst,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic [15:0] bus_in,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        cpu_hold,
  output logic        busy,
  output logic        out_overflow
);
  typedef enum logic [2:0] {IDLE, START, FETCH, ADDR, DATA, RELEASE, RUN} state_t;
  state_t state, state_d;
  logic [7:0] addr, count;
  logic [15:0] word, in_buf;
  logic in_full, go, rd, wr, serve;
  always_comb begin
    go = load_start & (state == IDLE | state == RUN);
    wr = state == RUN & cpu_write;
    rd = state == RUN & cpu_read & ~cpu_write;
    serve = rd & in_full;
    state_d = state;
    case (state)
      START:   state_d = FETCH;
      FETCH:   state_d = wr_valid ? ADDR : FETCH;
      ADDR:    state_d = DATA;
      DATA:    state_d = addr == count ? RELEASE : FETCH;
      RELEASE: state_d = RUN;
      default: state_d = state;
    endcase
    if (go) state_d = START;
    wr_ready = state == FETCH;
    pgrm_addr = state == ADDR;
    pgrm_data = state == DATA;
    cpu_rst = state == START | state == RELEASE;
    busy = state != IDLE & state != RUN;
    bus_oe = pgrm_addr | pgrm_data | serve;
    bus_out = pgrm_addr ? {8'h00, addr} : pgrm_data ? word : serve ? in_buf : 16'h0000;
    cpu_hold = rd & ~in_full;
    // in_ready stays low while reset is held so reset presents all-zero outputs
    in_ready = rst & ~in_full;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      count <= '0;
      word <= '0;
      in_buf <= '0;
      in_full <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        count <= load_count;
        addr <= '0;
        in_full <= 1'b0;
        out_valid <= 1'b0;
        out_overflow <= 1'b0;
      end else begin
        if (state == FETCH && wr_valid) word <= wr_data;
        if (state == DATA && addr != count) addr <= addr + 8'd1;
        if (in_valid && in_ready) begin
          in_full <= 1'b1;
          in_buf <= in_data;
        end else if (serve) in_full <= 1'b0;
        if (wr) begin
          out_data <= bus_in;
          out_valid <= 1'b1;
          if (out_valid && !out_ready) out_overflow <= 1'b1;
        end else if (out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule
